// File: rtl/line_table_arbiter.sv
// Two-port round-robin arbiter (with lock) over a 4-entry line table with per-half masked write/read.
// Reads respond one cycle after acceptance; ready is combinational from valids and arbiter state.
module line_table_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic         a_we,
  input  logic [1:0]   a_mask,
  input  logic [1:0]   a_idx,
  input  logic [W-1:0] a_wdata,
  input  logic         a_lock,
  output logic         a_rvalid,
  output logic [W-1:0] a_rdata,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic         b_we,
  input  logic [1:0]   b_mask,
  input  logic [1:0]   b_idx,
  input  logic [W-1:0] b_wdata,
  input  logic         b_lock,
  output logic         b_rvalid,
  output logic [W-1:0] b_rdata
);
  localparam int H = W / 2;

  typedef enum logic [1:0] {RR, LOCK_A, LOCK_B} state_t;

  state_t       r_state, w_state_nxt;
  logic         r_ptr_b, w_ptr_b_nxt;
  logic [W-1:0] r_tab [4];

  logic         w_ptr_eff_b;
  logic         w_acc_a, w_acc_b, w_acc;
  logic         w_we;
  logic [1:0]   w_mask, w_idx;
  logic [W-1:0] w_wdata, w_entry, w_rd;

  // During reset the grant follows the RR rule with the pointer at A.
  assign w_ptr_eff_b = r_ptr_b && !rst;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst || r_state == RR) begin
      a_ready = a_valid && (!b_valid || !w_ptr_eff_b);
      b_ready = b_valid && (!a_valid || w_ptr_eff_b);
    end else if (r_state == LOCK_A) begin
      a_ready = a_valid;
    end else if (r_state == LOCK_B) begin
      b_ready = b_valid;
    end
  end

  assign w_acc_a = a_valid && a_ready && !rst;
  assign w_acc_b = b_valid && b_ready && !rst;
  assign w_acc   = w_acc_a || w_acc_b;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_b_nxt = r_ptr_b;
    if (w_acc_a)      w_ptr_b_nxt = 1'b1;
    else if (w_acc_b) w_ptr_b_nxt = 1'b0;
    case (r_state)
      RR: begin
        if (w_acc_a && a_lock)      w_state_nxt = LOCK_A;
        else if (w_acc_b && b_lock) w_state_nxt = LOCK_B;
      end
      LOCK_A: if (!a_valid || (w_acc_a && !a_lock)) w_state_nxt = RR;
      LOCK_B: if (!b_valid || (w_acc_b && !b_lock)) w_state_nxt = RR;
      default: w_state_nxt = RR;
    endcase
  end

  // At most one port is accepted per cycle, so a single shared access path suffices.
  assign w_we    = w_acc_b ? b_we    : a_we;
  assign w_mask  = w_acc_b ? b_mask  : a_mask;
  assign w_idx   = w_acc_b ? b_idx   : a_idx;
  assign w_wdata = w_acc_b ? b_wdata : a_wdata;

  assign w_entry = (w_idx == 2'd0) ? {W{1'b0}} : r_tab[w_idx];
  assign w_rd    = {(w_mask[1] ? w_entry[W-1:H] : {(W-H){1'b0}}),
                    (w_mask[0] ? w_entry[H-1:0] : {H{1'b0}})};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RR;
      r_ptr_b  <= 1'b0;
      for (int i = 0; i < 4; i++) r_tab[i] <= {W{1'b0}};
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= {W{1'b0}};
      b_rdata  <= {W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_ptr_b  <= w_ptr_b_nxt;
      if (w_acc && w_we && (w_idx != 2'd0)) begin
        if (w_mask[1]) r_tab[w_idx][W-1:H] <= w_wdata[W-1:H];
        if (w_mask[0]) r_tab[w_idx][H-1:0] <= w_wdata[H-1:0];
      end
      a_rvalid <= w_acc_a && !a_we;
      b_rvalid <= w_acc_b && !b_we;
      if (w_acc_a && !a_we) a_rdata <= w_rd;
      if (w_acc_b && !b_we) b_rdata <= w_rd;
    end
  end
endmodule

// File: tb/tb_line_table_arbiter.sv
// Directed bench for line_table_arbiter: inputs change 1 time unit after the rising edge, outputs checked there too.
module tb_line_table_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_ready, a_we, a_lock, a_rvalid;
  logic [1:0] a_mask, a_idx;
  logic [7:0] a_wdata, a_rdata;
  logic       b_valid, b_ready, b_we, b_lock, b_rvalid;
  logic [1:0] b_mask, b_idx;
  logic [7:0] b_wdata, b_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  line_table_arbiter #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_mask(a_mask), .a_idx(a_idx),
    .a_wdata(a_wdata), .a_lock(a_lock), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_mask(b_mask), .b_idx(b_idx),
    .b_wdata(b_wdata), .b_lock(b_lock), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic we, input logic [1:0] m,
                       input logic [1:0] i, input logic [7:0] d, input logic l);
    a_valid = v; a_we = we; a_mask = m; a_idx = i; a_wdata = d; a_lock = l;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [1:0] m,
                       input logic [1:0] i, input logic [7:0] d, input logic l);
    b_valid = v; b_we = we; b_mask = m; b_idx = i; b_wdata = d; b_lock = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_a(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, 1'b0);
    set_b(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, 1'b0);
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rst_a_ready got %b want 1", a_ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL rst_b_ready got %b want 0", b_ready); end
    tick(); tick();
    n_cmp++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_a_rvalid got %b want 0", a_rvalid); end
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_b_rvalid got %b want 0", b_rvalid); end
    n_cmp++; if (a_rdata !== 8'h00) begin n_err++; $display("FAIL rst_a_rdata got %h want 00", a_rdata); end
    n_cmp++; if (b_rdata !== 8'h00) begin n_err++; $display("FAIL rst_b_rdata got %h want 00", b_rdata); end
    set_a(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    set_b(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    set_a(1'b1, 1'b1, 2'b11, 2'd2, 8'h8F, 1'b0);
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL wr_a_ready got %b want 1", a_ready); end
    tick();
    n_cmp++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid got %b want 0", a_rvalid); end
    set_a(1'b1, 1'b0, 2'b11, 2'd2, 8'h00, 1'b0);
    tick();
    set_a(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    n_cmp++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_a_rvalid got %b want 1", a_rvalid); end
    n_cmp++; if (a_rdata !== 8'h8F) begin n_err++; $display("FAIL rd_a_rdata got %h want 8f", a_rdata); end
    tick();
    n_cmp++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_a_pulse got %b want 0", a_rvalid); end
    n_cmp++; if (a_rdata !== 8'h8F) begin n_err++; $display("FAIL rd_a_hold got %h want 8f", a_rdata); end
  endtask

  task automatic test_half_mask();
    set_b(1'b1, 1'b1, 2'b10, 2'd2, 8'h50, 1'b0);
    tick();
    set_b(1'b1, 1'b0, 2'b11, 2'd2, 8'h00, 1'b0);
    tick();
    n_cmp++; if (b_rdata !== 8'h5F || b_rvalid !== 1'b1) begin n_err++; $display("FAIL half_m11 got %h/%b want 5f/1", b_rdata, b_rvalid); end
    set_b(1'b1, 1'b0, 2'b01, 2'd2, 8'h00, 1'b0);
    tick();
    n_cmp++; if (b_rdata !== 8'h0F || b_rvalid !== 1'b1) begin n_err++; $display("FAIL half_m01 got %h/%b want 0f/1", b_rdata, b_rvalid); end
    set_b(1'b1, 1'b0, 2'b10, 2'd2, 8'h00, 1'b0);
    tick();
    n_cmp++; if (b_rdata !== 8'h50) begin n_err++; $display("FAIL half_m10 got %h want 50", b_rdata); end
    set_b(1'b1, 1'b1, 2'b11, 2'd0, 8'hFF, 1'b0);
    tick();
    set_b(1'b1, 1'b0, 2'b11, 2'd0, 8'h00, 1'b0);
    tick();
    set_b(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    n_cmp++; if (b_rdata !== 8'h00 || b_rvalid !== 1'b1) begin n_err++; $display("FAIL entry0 got %h/%b want 00/1", b_rdata, b_rvalid); end
    tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_a(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, 1'b0);
    set_b(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        n_err++; $display("FAIL rr_grant beat %0d got a=%b b=%b want a=%b", i, a_ready, b_ready, (i % 2 == 0));
      end
      tick();
      n_cmp++; if (a_rvalid !== (i % 2 == 0) || b_rvalid !== (i % 2 == 1)) begin
        n_err++; $display("FAIL rr_rvalid beat %0d got a=%b b=%b want a=%b", i, a_rvalid, b_rvalid, (i % 2 == 0));
      end
    end
  endtask

  task automatic test_lock();
    // Pointer is back at A after the alternating A,B,A,B sequence.
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, (i < 3));
      #1;
      n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
        n_err++; $display("FAIL lock_beat %0d got a=%b b=%b want a=1 b=0", i, a_ready, b_ready);
      end
      tick();
    end
    set_a(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, 1'b0);
    #1;
    n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin n_err++; $display("FAIL lock_release got a=%b b=%b want a=0 b=1", a_ready, b_ready); end
    tick();
    set_a(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, 1'b1);
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL abandon_grant got %b want 1", a_ready); end
    tick();
    set_a(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    #1;
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL abandon_locked got %b want 0", b_ready); end
    tick();
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL abandon_b_next got %b want 1", b_ready); end
    set_b(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_raw();
    set_a(1'b1, 1'b1, 2'b11, 2'd3, 8'h66, 1'b0);
    tick();
    set_a(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    set_b(1'b1, 1'b0, 2'b11, 2'd3, 8'h00, 1'b0);
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL raw_b_ready got %b want 1", b_ready); end
    tick();
    set_b(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    n_cmp++; if (b_rdata !== 8'h66 || b_rvalid !== 1'b1) begin n_err++; $display("FAIL raw_b_rdata got %h/%b want 66/1", b_rdata, b_rvalid); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    set_a(1'b1, 1'b0, 2'b11, 2'd3, 8'h00, 1'b1);
    tick();
    n_cmp++; if (a_rdata !== 8'h66 || a_rvalid !== 1'b1) begin n_err++; $display("FAIL mid_pre got %h/%b want 66/1", a_rdata, a_rvalid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rvalid got %b want 0", a_rvalid); end
    n_cmp++; if (a_rdata !== 8'h00) begin n_err++; $display("FAIL mid_rdata got %h want 00", a_rdata); end
    set_a(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    set_b(1'b1, 1'b0, 2'b11, 2'd3, 8'h00, 1'b0);
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL mid_unlocked got %b want 1", b_ready); end
    tick();
    set_b(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    n_cmp++; if (b_rdata !== 8'h00 || b_rvalid !== 1'b1) begin n_err++; $display("FAIL mid_table got %h/%b want 00/1", b_rdata, b_rvalid); end
    set_a(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, 1'b0);
    set_b(1'b1, 1'b0, 2'b11, 2'd1, 8'h00, 1'b0);
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL mid_ptr got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set_a(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    set_b(1'b0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    tick();
    test_reset();
    test_write_read();
    test_half_mask();
    test_round_robin();
    test_lock();
    test_raw();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
